// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the generic pipeline stage register.
// Covers the NOP and zero words, hold-level encodings, FSM state encodings,
// and the per-entry update operations.
package pipe_stage_skid_pkg;

   // Canonical bubble: addi x0, x0, 0
   localparam logic [31:0] INST_NOP  = 32'h0000_0013;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // Hold flag bus width and the levels the controller can raise
   localparam int          HOLD_FLAG_BUS_W = 3;
   localparam logic [2:0]  HOLD_NONE       = 3'd0;
   localparam logic [2:0]  HOLD_PC         = 3'd1;
   localparam logic [2:0]  HOLD_IF         = 3'd2;
   localparam logic [2:0]  HOLD_ID         = 3'd3;

   typedef enum logic [1:0] {
      PSS_EMPTY = 2'd0,   // no payload held
      PSS_BUSY  = 2'd1,   // main entry valid
      PSS_FULL  = 2'd2    // main and skid entries valid
   } pss_state_e;

   typedef enum logic [1:0] {
      MAIN_KEEP,
      MAIN_LOAD_IN,
      MAIN_LOAD_SKID,
      MAIN_CLEAR
   } main_op_e;

   typedef enum logic [1:0] {
      SKID_KEEP,
      SKID_LOAD_IN,
      SKID_CLEAR
   } skid_op_e;

endpackage

// File: rtl/pipe_stage_fsm.sv
// Control FSM for pipe_stage_skid: holds the occupancy state, decodes the
// handshake outputs from state, and tells the datapath how to update the
// main and skid entries each cycle.
module pipe_stage_fsm
   import pipe_stage_skid_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_in_valid,
   input  logic       i_out_ready,
   input  logic       i_hold_en,
   input  logic       i_flush,
   output pss_state_e o_state,
   output logic       o_in_ready,
   output logic       o_out_valid,
   output main_op_e   o_main_op,
   output skid_op_e   o_skid_op
);

   pss_state_e r_state;
   pss_state_e w_state_nxt;
   logic       w_in_fire;
   logic       w_out_fire;

   // Ready depends only on occupancy and hold, never on downstream ready,
   // so back-pressure does not ripple combinationally upstream.
   assign o_in_ready  = ~rst & (r_state != PSS_FULL) & ~i_hold_en;
   assign o_out_valid = (r_state != PSS_EMPTY) & ~i_hold_en;
   assign w_in_fire   = i_in_valid & o_in_ready;
   assign w_out_fire  = o_out_valid & i_out_ready;
   assign o_state     = r_state;

   // Next-state and entry-operation decode: flush, then hold, then handshake
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
      w_state_nxt = r_state;
      o_main_op   = MAIN_KEEP;
      o_skid_op   = SKID_KEEP;
      if (i_flush) begin
         w_state_nxt = PSS_EMPTY;
         o_main_op   = MAIN_CLEAR;
         o_skid_op   = SKID_CLEAR;
      end else if (!i_hold_en) begin
         case (r_state)
            PSS_EMPTY: begin
               if (w_in_fire) begin
                  w_state_nxt = PSS_BUSY;
                  o_main_op   = MAIN_LOAD_IN;
               end
            end
            PSS_BUSY: begin
               if (w_in_fire && w_out_fire) begin
                  o_main_op   = MAIN_LOAD_IN;
               end else if (w_in_fire) begin
                  w_state_nxt = PSS_FULL;
                  o_skid_op   = SKID_LOAD_IN;
               end else if (w_out_fire) begin
                  w_state_nxt = PSS_EMPTY;
                  o_main_op   = MAIN_CLEAR;
               end
            end
            PSS_FULL: begin
               if (w_out_fire) begin
                  w_state_nxt = PSS_BUSY;
                  o_main_op   = MAIN_LOAD_SKID;
                  o_skid_op   = SKID_CLEAR;
               end
            end
            default: begin
               w_state_nxt = PSS_EMPTY;
               o_main_op   = MAIN_CLEAR;
               o_skid_op   = SKID_CLEAR;
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (rst) r_state <= PSS_EMPTY;
      else     r_state <= w_state_nxt;
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, 2-entry skid
// buffer, flush-to-bubble and hold-level freeze.
// Optional stall counter enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int                 DW         = 32,
   parameter logic [31:0]        NOP_VAL    = INST_NOP,
   parameter int                 HOLD_W     = HOLD_FLAG_BUS_W,
   parameter logic [HOLD_W-1:0]  HOLD_LEVEL = HOLD_IF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
`ifdef PIPE_STAGE_STATS_EN
   output logic [15:0]       stall_cnt_o,
`endif
   input  logic [HOLD_W-1:0] hold_flag_i,
   input  logic              flush_i
);

   localparam logic [DW-1:0] NOP_DW = DW'(NOP_VAL);

   logic        w_hold_en;
   pss_state_e  w_state;
   main_op_e    w_main_op;
   skid_op_e    w_skid_op;
   logic [DW-1:0] r_main;
   logic [DW-1:0] r_skid;

   assign w_hold_en = (hold_flag_i >= HOLD_LEVEL);

   pipe_stage_fsm u_fsm (
      .clk         (clk),
      .rst         (rst),
      .i_in_valid  (in_valid),
      .i_out_ready (out_ready),
      .i_hold_en   (w_hold_en),
      .i_flush     (flush_i),
      .o_state     (w_state),
      .o_in_ready  (in_ready),
      .o_out_valid (out_valid),
      .o_main_op   (w_main_op),
      .o_skid_op   (w_skid_op)
   );

   // Main and skid payload entries, updated as the FSM directs
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the entries are reset because a bubble must be visible on out_data straight out of reset.
      if (rst) begin
         r_main <= NOP_DW;
         r_skid <= NOP_DW;
      end else begin
         case (w_main_op)
            MAIN_LOAD_IN:   r_main <= in_data;
            MAIN_LOAD_SKID: r_main <= r_skid;
            MAIN_CLEAR:     r_main <= NOP_DW;
            default:        ;
         endcase
         case (w_skid_op)
            SKID_LOAD_IN:   r_skid <= in_data;
            SKID_CLEAR:     r_skid <= NOP_DW;
            default:        ;
         endcase
      end
   end

   assign out_data = (w_state == PSS_EMPTY) ? NOP_DW : r_main;

`ifdef PIPE_STAGE_STATS_EN
   logic [15:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = (out_valid & ~out_ready) | w_hold_en;

   // Saturating count of cycles the stage is stalled or back-pressured
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 r_stall_cnt <= 16'h0000;
      else if (flush_i)                        r_stall_cnt <= 16'h0000;
      else if (w_stall && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'h0001;
   end

   assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed, self-checking bench for pipe_stage_skid with a payload scoreboard.
// Stall-counter checks compile in when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_skid;
   import pipe_stage_skid_pkg::*;

   localparam int          DW         = 32;
   localparam logic [31:0] NOP        = 32'h0000_0013;
   localparam logic [2:0]  HOLD_LEVEL = 3'd2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [2:0]    hold_flag_i;
   logic          flush_i;
`ifdef PIPE_STAGE_STATS_EN
   logic [15:0]   stall_cnt_o;
`endif

   int checks   = 0;
   int failures = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   pipe_stage_skid #(
      .DW(DW), .NOP_VAL(NOP), .HOLD_W(3), .HOLD_LEVEL(HOLD_LEVEL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
`ifdef PIPE_STAGE_STATS_EN
      .stall_cnt_o (stall_cnt_o),
`endif
      .hold_flag_i (hold_flag_i),
      .flush_i     (flush_i)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are driven
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      sb.push_back(d);
   endtask

   // Scoreboard: every downstream transfer must match the oldest accepted payload
   always @(negedge clk) begin
      logic [31:0] exp_d;
      if (!rst && out_valid && out_ready) begin
         checks++;
         assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL sb_unexpected observed=%h expected=none", out_data);
         end
         if (sb.size() > 0) begin
            exp_d = sb.pop_front();
            check("sb_data", out_data, exp_d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      hold_flag_i = 3'd0; flush_i = 1'b0;

      // Reset state
      #3;
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  out_data,       NOP);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_state",    32'(dut.w_state), 32'(PSS_EMPTY));

      // 1. Streaming with out_ready high
      cyc(); out_ready = 1'b1; drive_in(32'h1);
      cyc(); drive_in(32'h2);
      @(negedge clk);
      check("t1_latency", 32'(out_valid), 32'd1);
      check("t1_ready_a", 32'(in_ready),  32'd1);
      cyc(); drive_in(32'h3);
      @(negedge clk);
      check("t1_ready_b", 32'(in_ready),  32'd1);
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      check("t1_last_valid", 32'(out_valid), 32'd1);
      cyc();
      @(negedge clk);
      check("t1_drained", 32'(out_valid), 32'd0);
      check("t1_sb_empty", sb.size(), 32'd0);

      // 2. Back-pressure fills the skid entry
      cyc(); out_ready = 1'b0; drive_in(32'hA);
      cyc(); drive_in(32'hB);
      @(negedge clk);
      check("t2_busy_ready", 32'(in_ready), 32'd1);
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      check("t2_full_state", 32'(dut.w_state), 32'(PSS_FULL));
      check("t2_full_ready", 32'(in_ready),    32'd0);
      check("t2_full_data",  out_data,         32'hA);
      cyc();
      @(negedge clk);
      check("t2_full_hold_data", out_data, 32'hA);
      cyc(); out_ready = 1'b1;
      cyc();
      @(negedge clk);
      check("t2_ready_back", 32'(in_ready), 32'd1);
      check("t2_second_out", out_data,      32'hB);
      cyc();
      @(negedge clk);
      check("t2_drained", 32'(out_valid), 32'd0);

      // 3. Hold freezes the stage
      cyc(); out_ready = 1'b0; drive_in(32'h55);
      cyc(); in_valid = 1'b0; hold_flag_i = HOLD_LEVEL; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_hold_valid", 32'(out_valid), 32'd0);
         check("t3_hold_ready", 32'(in_ready),  32'd0);
         check("t3_hold_main",  dut.r_main,     32'h55);
         cyc();
      end
      hold_flag_i = 3'd0;
      @(negedge clk);
      check("t3_release", out_data, 32'h55);
      cyc();
      @(negedge clk);
      check("t3_once", 32'(out_valid), 32'd0);
      cyc(); out_ready = 1'b0; hold_flag_i = 3'(HOLD_LEVEL - 3'd1); drive_in(32'h66);
      @(negedge clk);
      check("t3_below_ready", 32'(in_ready), 32'd1);
      cyc(); in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("t3_below_valid", 32'(out_valid), 32'd1);
      cyc(); hold_flag_i = 3'd0;

      // 4. Flush beats hold and drops the incoming payload
      out_ready = 1'b0; drive_in(32'h10);
      cyc(); drive_in(32'h20);
      cyc();
      flush_i = 1'b1; hold_flag_i = HOLD_LEVEL; in_valid = 1'b1; in_data = 32'h30;
      sb.delete();
      cyc(); flush_i = 1'b0; hold_flag_i = 3'd0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("t4_state",     32'(dut.w_state), 32'(PSS_EMPTY));
      check("t4_out_valid", 32'(out_valid),   32'd0);
      check("t4_out_data",  out_data,         NOP);
      cyc();
      @(negedge clk);
      check("t4_no_0x30", 32'(out_valid), 32'd0);

      // 5. Asynchronous reset while FULL
      cyc(); out_ready = 1'b0; drive_in(32'h77);
      cyc(); drive_in(32'h88);
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      check("t5_pre_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      sb.delete();
      #1;
      check("t5_async_valid", 32'(out_valid), 32'd0);
      check("t5_async_data",  out_data,       NOP);
      check("t5_async_ready", 32'(in_ready),  32'd0);
      cyc(); rst = 1'b0;
      @(negedge clk);
      check("t5_post_state", 32'(dut.w_state), 32'(PSS_EMPTY));

`ifdef PIPE_STAGE_STATS_EN
      // 6. Stall counter
      check("t6_cnt_reset", 32'(stall_cnt_o), 32'd0);
      cyc(); out_ready = 1'b0; drive_in(32'h99);
      cyc(); in_valid = 1'b0;
      repeat (5) cyc();
      @(negedge clk);
      check("t6_cnt_five", 32'(stall_cnt_o), 32'd5);
      cyc(); flush_i = 1'b1; sb.delete();
      cyc(); flush_i = 1'b0;
      @(negedge clk);
      check("t6_cnt_flush", 32'(stall_cnt_o), 32'd0);
      cyc(); drive_in(32'hAA);
      cyc(); in_valid = 1'b0;
      @(negedge clk);
      force dut.r_stall_cnt = 16'hFFFD;
      #1 release dut.r_stall_cnt;
      repeat (4) cyc();
      @(negedge clk);
      check("t6_cnt_sat", 32'(stall_cnt_o), 32'h0000_FFFF);
      cyc(); flush_i = 1'b1; sb.delete();
      cyc(); flush_i = 1'b0;
`endif

      cyc();
      check("sb_drain", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, width-parametrised pipeline stage register for the tiny_riscv core.
- Generalises the fixed per-signal ID/EX latch:
  - one packed payload bus;
  - valid/ready handshake with a 2-entry skid buffer, so back-pressure does not create a combinational ready path;
  - flush with bubble (NOP) insertion;
  - hold-flag freeze at a configurable level.
- Instantiated between any two core stages (IF/ID, ID/EX, EX/MEM).

Parameters:
- DW, 32, payload width in bits (packed inst, addr, operands, etc.).
- NOP_VAL, 32'h00000013, payload value driven when the stage is empty or flushed; only low DW bits used.
- HOLD_W, 3, width of the hold flag bus.
- HOLD_LEVEL, 3'd2, stage freezes when hold_flag_i >= HOLD_LEVEL.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept the payload this cycle.
- in_data  in  DW  upstream payload.
- out_valid  out  1  payload valid to downstream.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  DW  payload to downstream.
- hold_flag_i  in  HOLD_W  core hold/stall level from the controller.
- flush_i  in  1  kill all held entries (jump/trap).
- stall_cnt_o  out  16  saturating stall counter; present only with PIPE_STAGE_STATS_EN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values:
  - state EMPTY; main and skid entries = NOP_VAL, both invalid.
  - out_valid = 0, out_data = NOP_VAL, in_ready = 0 while rst is high, stall_cnt_o = 0.
- Derived signals:
  - hold_en = (hold_flag_i >= HOLD_LEVEL), unsigned compare.
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Output decode:
  - in_ready = (state != FULL) & ~hold_en; decoded from state only, never from out_ready.
  - out_valid = main_valid & ~hold_en.
  - out_data = main entry; NOP_VAL when main is invalid.
- Latency: 1 cycle from in_fire to out_valid when the stage is EMPTY or draining.
- FSM states: EMPTY, BUSY (main valid), FULL (main + skid valid).
  - EMPTY: in_fire -> BUSY, main <= in_data.
  - BUSY, in_fire & out_fire -> BUSY, main <= in_data.
  - BUSY, in_fire & ~out_fire -> FULL, skid <= in_data.
  - BUSY, ~in_fire & out_fire -> EMPTY, main <= NOP_VAL.
  - FULL: out_fire -> BUSY, main <= skid, skid <= NOP_VAL. No input is accepted in FULL.
- Priority, highest first:
  1. rst (async).
  2. flush_i: next state EMPTY, both entries <= NOP_VAL; in_data is dropped even if in_valid is high.
  3. hold_en: state and entries frozen; no fire on either side.
  4. Handshake transitions.
- Payload ordering: strictly FIFO. The skid entry is never overwritten while valid. Data is never duplicated or lost except on flush.
- Simultaneous flush + hold: flush wins; the stage is EMPTY after the edge.
- rst asserted mid-transfer: all entries are discarded immediately; no partial payload is emitted.
- in_valid may drop without a transfer; the stage never requires a held valid.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- Defined:
  - stall_cnt_o port exists.
  - Increments by 1 on every cycle where (out_valid & ~out_ready) | hold_en.
  - Saturates at 16'hFFFF.
  - Cleared by rst and by flush_i.
- Undefined: the port and counter are absent; zero extra flops.

Decomposition:
- defines.v owns:
  - INST_NOP (default for NOP_VAL);
  - ZeroWord;
  - the Hold_Flag_Bus width and the Hold_* levels used for HOLD_LEVEL per instance;
  - state encodings PSS_EMPTY=2'd0, PSS_BUSY=2'd1, PSS_FULL=2'd2.
- One natural sub-module: pipe_stage_fsm.
  - Holds state, next-state logic, and the load/shift enables for main and skid.
  - Datapath regs stay in pipe_stage_skid.

Test Plan:
1. Reset, then stream in_data 0x1,0x2,0x3 with out_ready=1 -> out_data 0x1,0x2,0x3 on consecutive cycles, each 1 cycle after its in_fire; in_ready stays 1.
2. Back-pressure:
   - Stimulus: out_ready=0 while sending 0xA,0xB.
   - Required: state FULL, in_ready=0.
   - Then out_ready=1 -> 0xA then 0xB out in order; in_ready returns to 1 after the first out_fire.
3. Hold:
   - Stimulus: hold_flag_i=HOLD_LEVEL for 3 cycles while BUSY with 0x55.
   - Required: out_valid=0, in_ready=0, main stays 0x55.
   - Then hold_flag_i=0 -> 0x55 is emitted once.
   - Also: hold_flag_i=HOLD_LEVEL-1 causes no freeze.
4. Flush:
   - Stimulus: in FULL (0x10,0x20), assert flush_i together with hold_en and in_valid (0x30).
   - Required: next cycle EMPTY, out_valid=0, out_data=NOP_VAL; 0x30 never appears.
5. Async reset: assert rst between clock edges while FULL -> out_valid=0 and out_data=NOP_VAL immediately, before the next edge.
6. With PIPE_STAGE_STATS_EN:
   - 5 back-pressure cycles -> stall_cnt_o=5; flush -> 0.
   - Preload near 16'hFFFF (force), continue stalling -> stays 16'hFFFF.
